// File: rtl/ins_fetch_pipe_pkg.sv
// Shared fetch-stage constants and PC helpers.
package ifetch_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;  // reserved, not handled by fetch

  // Sequential next PC; wraps naturally at the top of the address space.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // J-format target: region bits from the delay-free pc4, word index from the instruction.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/ins_fetch_pipe_if.sv
// Fetch-stage bus: execute redirect, instruction memory port, decode handshake.
interface ins_fetch_pipe_if #(parameter int ADDR_W = 32);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-3:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc4;

  modport master (
    input  redirect, redirect_pc, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
  );
endinterface

// File: rtl/ins_fetch_pipe_fifo.sv
// Shift-register FIFO: entry 0 is always the head, so the head is a plain register.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  input  logic                         clear,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         valid,
  output logic [WIDTH-1:0]             head
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        pop_ok;
  logic [CW-1:0]               wr_idx;

  assign pop_ok = pop && (count != '0);
  // After a same-cycle pop everything slides down one slot, so the write lands one lower.
  assign wr_idx = count - CW'(pop_ok);
  assign valid  = (count != '0);
  assign head   = mem[0];

  // Storage shift/write and occupancy; clear only drops occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      mem   <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      if (pop_ok)
        for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
      for (int i = 0; i < DEPTH; i++)
        if (push && (wr_idx == CW'(i))) mem[i] <= din;
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/ins_fetch_pipe.sv
// Decoupled instruction fetch: PC sequencing, epoch-tagged 1-cycle memory reads,
// credit-limited FIFO toward decode, external redirect and early J redirect.
module ins_fetch_pipe
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter bit                EARLY_JUMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  ins_fetch_pipe_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = 32 + ADDR_W;

  logic [ADDR_W-1:0] pc, req_pc, jmp_pc, head_pc;
  logic              epoch, req_epoch, inflight;
  logic              rsp_ok, take_j, issue, fifo_valid;
  logic [CW-1:0]     count;
  logic [FW-1:0]     head;
  logic [31:0]       head_instr;

  // A response is kept only if its epoch is current and no redirect flushes it this cycle.
  assign rsp_ok = inflight && (req_epoch == epoch) && !bus.redirect;
  assign take_j = EARLY_JUMP && rsp_ok && (bus.imem_rdata[31:26] == OP_J);
  // Credits count the response still in flight; a pop frees its slot only next cycle.
  assign issue  = reset && !bus.redirect && !take_j &&
                  ((32'(count) + 32'(inflight)) < DEPTH);
  assign jmp_pc = ADDR_W'(jump_target(pc_plus4(32'(req_pc)), bus.imem_rdata));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc[ADDR_W-1:2];

  ifetch_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_ok),
    .din   ({bus.imem_rdata, req_pc}),
    .pop   (bus.if_valid && bus.if_ready && !bus.redirect),
    .clear (bus.redirect),
    .count (count),
    .valid (fifo_valid),
    .head  (head)
  );

  assign {head_instr, head_pc} = head;
  assign bus.if_valid = fifo_valid;
  assign bus.if_instr = head_instr;
  assign bus.if_pc    = head_pc;
  assign bus.if_pc4   = fifo_valid ? ADDR_W'(pc_plus4(32'(head_pc))) : '0;

  // PC/epoch update: redirect beats early jump beats sequential advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      epoch     <= 1'b0;
      inflight  <= 1'b0;
      req_pc    <= '0;
      req_epoch <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc    <= pc;
        req_epoch <= epoch;
      end
      if (bus.redirect) begin
        pc    <= bus.redirect_pc & ~ADDR_W'(3);
        epoch <= ~epoch;
      end else if (take_j) begin
        pc    <= jmp_pc;
        epoch <= ~epoch;
      end else if (issue) begin
        pc    <= ADDR_W'(pc_plus4(32'(pc)));
      end
    end
  end
endmodule
